// File: rtl/writeback_arbiter.sv
// writeback_arbiter
// Shares the single register-file write port between the in-order pipeline
// writeback (W stage) and a long-latency unit (LLU) whose results arrive out
// of band. LLU results are buffered in a small FIFO. The pipeline has
// priority. A starvation counter forces a one-cycle pipeline freeze
// (wb_stall) when the FIFO head has waited too long. A destination busy mask
// is exported so the hazard unit can hold dependent instructions.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   RegWriteW/RdW/ResultW   pipeline write request, destination, data
//   llu_issue/llu_issue_rd  LLU op dispatched this cycle and its destination
//   llu_valid/llu_ready     LLU result handshake (ready depends on state only)
//   llu_rd/llu_data         LLU result destination and data
//   rf_we/rf_waddr/rf_wdata register-file write port (combinational)
//   busy_mask               bit i set = x_i awaits an LLU result (registered)
//   wb_stall                one-cycle whole-pipeline freeze (registered)
//   pending_count           FIFO occupancy (registered)
module writeback_arbiter #(
    parameter int word_width   = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       RegWriteW,
    input  logic [4:0]                 RdW,
    input  logic [word_width-1:0]      ResultW,
    input  logic                       llu_issue,
    input  logic [4:0]                 llu_issue_rd,
    input  logic                       llu_valid,
    output logic                       llu_ready,
    input  logic [4:0]                 llu_rd,
    input  logic [word_width-1:0]      llu_data,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [word_width-1:0]      rf_wdata,
    output logic [31:0]                busy_mask,
    output logic                       wb_stall,
    output logic [$clog2(DEPTH+1)-1:0] pending_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);
    localparam logic [STV_W-1:0] STV_ZERO = STV_W'(0);
    localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);

    // FIFO storage and control state
    logic [4:0]            fifo_rd_r   [DEPTH];
    logic [word_width-1:0] fifo_data_r [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [STV_W-1:0]      starve_r;
    logic                  stall_r;
    logic                  ready_en_r;
    logic [31:0]           busy_r;

    logic                  empty_s;
    logic                  full_s;
    logic                  pipe_req_s;
    logic                  pop_s;
    logic                  push_s;
    logic [4:0]            head_rd_s;
    logic [word_width-1:0] head_data_s;
    logic [CNT_W-1:0]      count_nxt_s;
    logic [STV_W-1:0]      starve_nxt_s;
    logic                  stall_nxt_s;
    logic [31:0]           set_mask_s;
    logic [31:0]           clr_mask_s;
    logic [31:0]           busy_nxt_s;

    // Circular pointer advance that works for any DEPTH, not just powers of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return PTR_ZERO;
        end else begin
            return p + PTR_ONE;
        end
    endfunction

    assign empty_s     = (count_r == {CNT_W{1'b0}});
    assign full_s      = (count_r == CNT_FULL);
    assign head_rd_s   = fifo_rd_r[rd_ptr_r];
    assign head_data_s = fifo_data_r[rd_ptr_r];

    // Nothing is granted while reset is held, so queued results are discarded
    // rather than written on the way out. The stall cycle masks the pipeline.
    assign pipe_req_s = reset_n && RegWriteW && (RdW != 5'd0) && !stall_r;

    // ready_en_r keeps llu_ready low until the first cycle after release.
    assign llu_ready = reset_n && ready_en_r && !full_s;
    assign push_s    = llu_valid && llu_ready;

    assign busy_mask     = busy_r;
    assign wb_stall      = stall_r;
    assign pending_count = count_r;

    // Write-port grant: pipeline first, else FIFO head (popped even when rd==0).
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = {word_width{1'b0}};
        pop_s    = 1'b0;
        if (pipe_req_s) begin
            rf_we    = 1'b1;
            rf_waddr = RdW;
            rf_wdata = ResultW;
        end else if (reset_n && !empty_s) begin
            pop_s    = 1'b1;
            rf_we    = (head_rd_s != 5'd0);
            rf_waddr = head_rd_s;
            rf_wdata = head_data_s;
        end else begin
            rf_we    = 1'b0;
            rf_waddr = 5'd0;
            rf_wdata = {word_width{1'b0}};
        end
    end

    // Next-state for occupancy, starvation counter, stall pulse and busy mask.
    always_comb begin
        count_nxt_s  = count_r;
        starve_nxt_s = starve_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_ONE;
        end else begin
            count_nxt_s = count_r;
        end

        if (empty_s || pop_s) begin
            starve_nxt_s = STV_ZERO;
        end else if (starve_r == STV_MAX) begin
            starve_nxt_s = STV_MAX;
        end else begin
            starve_nxt_s = starve_r + STV_ONE;
        end

        // starve_r only reaches the limit while the FIFO holds a head.
        stall_nxt_s = (starve_r == STV_MAX) && !pop_s;

        // Set is applied after clear so a same-cycle issue wins.
        clr_mask_s = (pop_s && (head_rd_s != 5'd0)) ? (32'd1 << head_rd_s) : 32'd0;
        set_mask_s = (llu_issue && (llu_issue_rd != 5'd0)) ? (32'd1 << llu_issue_rd) : 32'd0;
        busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd_r[i]   <= 5'd0;
                fifo_data_r[i] <= {word_width{1'b0}};
            end
            rd_ptr_r   <= PTR_ZERO;
            wr_ptr_r   <= PTR_ZERO;
            count_r    <= {CNT_W{1'b0}};
            starve_r   <= STV_ZERO;
            stall_r    <= 1'b0;
            ready_en_r <= 1'b0;
            busy_r     <= 32'd0;
        end else begin
            if (push_s) begin
                fifo_rd_r[wr_ptr_r]   <= llu_rd;
                fifo_data_r[wr_ptr_r] <= llu_data;
                wr_ptr_r              <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r    <= count_nxt_s;
            starve_r   <= starve_nxt_s;
            stall_r    <= stall_nxt_s;
            ready_en_r <= 1'b1;
            busy_r     <= busy_nxt_s;
        end
    end

endmodule
